// File: rtl/data_mem_mmio.sv
// -----------------------------------------------------------------------------
// data_mem_mmio
//
// Data-memory stage for the pipelined 16-bit core's MEM-stage port. Byte
// addresses below IO_BASE go to a word-addressed RAM. Addresses at and above
// IO_BASE go to a small I/O window: an output port, a synchronized input port,
// a free-running cycle counter and a status register with a sticky alignment
// error flag. Reads are combinational so the MEM/WB register can capture them
// in the same cycle. All writes take effect at the rising clock edge.
//
// Ports
//   clock          system clock, rising-edge active
//   reset          synchronous, active-high reset
//   dmemaddr       byte address from the core (words are 2-byte aligned)
//   dmemwdata      write data
//   dmemwrite      write enable
//   dmemread       read enable
//   dmemrdata      combinational read data (0 when not reading or misaligned)
//   io_in          asynchronous external input, double-flopped internally
//   io_out         registered output port
//   io_out_strobe  one-cycle pulse following each IO_OUT write
//   align_err      sticky misaligned-access flag, cleared through STATUS
// -----------------------------------------------------------------------------
module data_mem_mmio #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    output logic [15:0] dmemrdata,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic        io_out_strobe,
    output logic        align_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // I/O register offsets relative to IO_BASE.
    localparam logic [15:0] OFF_IO_OUT = 16'h0000;
    localparam logic [15:0] OFF_IO_IN  = 16'h0002;
    localparam logic [15:0] OFF_CYCLE  = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0006;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_IO_OUT,
        SEL_IO_IN,
        SEL_CYCLE,
        SEL_STATUS,
        SEL_NONE
    } sel_t;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [15:0] mem [DEPTH_WORDS];
    logic [15:0] cycle_cnt;
    logic [15:0] io_in_s1;
    logic [15:0] io_in_s2;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    sel_t             sel;
    logic [15:0]      io_offset;
    logic [IDX_W-1:0] ram_idx;
    logic             access;
    logic             misaligned;
    logic             wr_ok;

    // Upper address bits below IO_BASE are ignored, so RAM aliases with a
    // period of DEPTH_WORDS words.
    assign ram_idx    = dmemaddr[IDX_W:1];
    assign io_offset  = dmemaddr - IO_BASE;
    assign access     = dmemread | dmemwrite;
    assign misaligned = access & dmemaddr[0];
    // A write commits only when aligned and outside the reset cycle.
    assign wr_ok      = dmemwrite & ~dmemaddr[0] & ~reset;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves sel
        // unassigned; otherwise synthesis infers a latch.
        sel = SEL_NONE;
        if (dmemaddr < IO_BASE) begin
            sel = SEL_RAM;
        end else begin
            unique case (io_offset)
                OFF_IO_OUT: sel = SEL_IO_OUT;
                OFF_IO_IN:  sel = SEL_IO_IN;
                OFF_CYCLE:  sel = SEL_CYCLE;
                OFF_STATUS: sel = SEL_STATUS;
                default:    sel = SEL_NONE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Combinational read path; always reflects pre-edge state, so a write in
    // the same cycle is not visible until the next cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        dmemrdata = 16'h0000;
        if (dmemread && !dmemaddr[0]) begin
            unique case (sel)
                SEL_RAM:    dmemrdata = mem[ram_idx];
                SEL_IO_OUT: dmemrdata = io_out;
                SEL_IO_IN:  dmemrdata = io_in_s2;
                SEL_CYCLE:  dmemrdata = cycle_cnt;
                SEL_STATUS: dmemrdata = {15'b0, align_err};
                default:    dmemrdata = 16'h0000;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RAM write port
    // -------------------------------------------------------------------------
    // NOTE: the RAM array has no reset; clearing it would force it into
    // flops instead of a memory macro, and software does not rely on it.
    always_ff @(posedge clock) begin
        if (wr_ok && sel == SEL_RAM) begin
            mem[ram_idx] <= dmemwdata;
        end
    end

    // -------------------------------------------------------------------------
    // Output port and its strobe
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_out        <= 16'h0000;
            io_out_strobe <= 1'b0;
        end else begin
            io_out_strobe <= wr_ok && sel == SEL_IO_OUT;
            if (wr_ok && sel == SEL_IO_OUT) begin
                io_out <= dmemwdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Input port synchronizer: two stages, read side sees the second.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            io_in_s1 <= 16'h0000;
            io_in_s2 <= 16'h0000;
        end else begin
            io_in_s1 <= io_in;
            io_in_s2 <= io_in_s1;
        end
    end

    // -------------------------------------------------------------------------
    // Free-running cycle counter; a write replaces that cycle's increment.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= 16'h0000;
        end else if (wr_ok && sel == SEL_CYCLE) begin
            cycle_cnt <= dmemwdata;
        end else begin
            cycle_cnt <= cycle_cnt + 16'h0001;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky alignment error; a new error takes priority over a clear.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            align_err <= 1'b0;
        end else if (misaligned) begin
            align_err <= 1'b1;
        end else if (wr_ok && sel == SEL_STATUS && dmemwdata[0]) begin
            align_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// -----------------------------------------------------------------------------
// tb_data_mem_mmio
//
// Directed bench for data_mem_mmio. Inputs change on the falling edge; the
// combinational read path is sampled 1 time unit later and registered outputs
// are sampled on the falling edge after the committing rising edge.
// -----------------------------------------------------------------------------
module tb_data_mem_mmio;

    logic        clock;
    logic        reset;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic        io_out_strobe;
    logic        align_err;

    int n_compared;
    int n_mismatched;

    data_mem_mmio #(
        .DEPTH_WORDS(256),
        .IO_BASE    (16'hFF00)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dmemaddr     (dmemaddr),
        .dmemwdata    (dmemwdata),
        .dmemwrite    (dmemwrite),
        .dmemread     (dmemread),
        .dmemrdata    (dmemrdata),
        .io_in        (io_in),
        .io_out       (io_out),
        .io_out_strobe(io_out_strobe),
        .align_err    (align_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stimulus helpers (no comparisons inside).
    task automatic drive(input logic [15:0] a, input logic [15:0] w,
                         input logic wr, input logic rd);
        dmemaddr  = a;
        dmemwdata = w;
        dmemwrite = wr;
        dmemread  = rd;
    endtask

    task automatic idle();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    // Advance across one rising edge and land on the next falling edge.
    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_in = 16'h0000;
        idle();
        cyc();
        cyc();
        // Accesses during reset must be ignored.
        drive(16'hFF00, 16'h5A5A, 1'b1, 1'b0);
        cyc();
        drive(16'h0013, 16'h0000, 1'b1, 1'b0);
        cyc();
        drive(16'hFF04, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (io_out !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL reset_io_out: got %h want 0000", io_out);
        end
        n_compared++;
        if (io_out_strobe !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_strobe: got %b want 0", io_out_strobe);
        end
        n_compared++;
        if (align_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_align_err: got %b want 0", align_err);
        end
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL reset_cycle: got %h want 0000", dmemrdata);
        end
        @(negedge clock);
        reset = 1'b0;
        idle();
    endtask

    task automatic test_ram();
        drive(16'h0010, 16'h1234, 1'b1, 1'b0);
        cyc();
        drive(16'h0010, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h1234) begin
            n_mismatched++;
            $display("FAIL ram_read: got %h want 1234", dmemrdata);
        end
        dmemaddr = 16'h0210;
        #1;
        n_compared++;
        if (dmemrdata !== 16'h1234) begin
            n_mismatched++;
            $display("FAIL ram_alias: got %h want 1234", dmemrdata);
        end
        dmemread = 1'b0;
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL ram_noread: got %h want 0000", dmemrdata);
        end
        // Second word to show distinct indices do not collide.
        drive(16'h0012, 16'h4321, 1'b1, 1'b0);
        cyc();
        drive(16'h0010, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h1234) begin
            n_mismatched++;
            $display("FAIL ram_neighbor: got %h want 1234", dmemrdata);
        end
        dmemaddr = 16'h0012;
        #1;
        n_compared++;
        if (dmemrdata !== 16'h4321) begin
            n_mismatched++;
            $display("FAIL ram_word2: got %h want 4321", dmemrdata);
        end
        idle();
    endtask

    task automatic test_rw_same();
        drive(16'h0020, 16'hAAAA, 1'b1, 1'b0);
        cyc();
        drive(16'h0020, 16'h5555, 1'b1, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'hAAAA) begin
            n_mismatched++;
            $display("FAIL rw_old: got %h want AAAA", dmemrdata);
        end
        cyc();
        drive(16'h0020, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h5555) begin
            n_mismatched++;
            $display("FAIL rw_new: got %h want 5555", dmemrdata);
        end
        idle();
    endtask

    task automatic test_align();
        drive(16'h0011, 16'hBEEF, 1'b1, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL align_rdata: got %h want 0000", dmemrdata);
        end
        cyc();
        drive(16'h0010, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (align_err !== 1'b1) begin
            n_mismatched++;
            $display("FAIL align_set: got %b want 1", align_err);
        end
        n_compared++;
        if (dmemrdata !== 16'h1234) begin
            n_mismatched++;
            $display("FAIL align_nowrite: got %h want 1234", dmemrdata);
        end
        idle();
        cyc();
        cyc();
        n_compared++;
        if (align_err !== 1'b1) begin
            n_mismatched++;
            $display("FAIL align_sticky: got %b want 1", align_err);
        end
        // Clear via STATUS; read in the same cycle still shows the set bit.
        drive(16'hFF06, 16'h0001, 1'b1, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0001) begin
            n_mismatched++;
            $display("FAIL status_pre: got %h want 0001", dmemrdata);
        end
        cyc();
        drive(16'hFF06, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (align_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL align_clear: got %b want 0", align_err);
        end
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL status_read: got %h want 0000", dmemrdata);
        end
        // Misaligned read alone also flags.
        drive(16'h0021, 16'h0000, 1'b0, 1'b1);
        cyc();
        idle();
        n_compared++;
        if (align_err !== 1'b1) begin
            n_mismatched++;
            $display("FAIL align_read_set: got %b want 1", align_err);
        end
        drive(16'hFF06, 16'h0001, 1'b1, 1'b0);
        cyc();
        idle();
    endtask

    task automatic test_io_out();
        drive(16'hFF00, 16'h00C3, 1'b1, 1'b0);
        cyc();
        idle();
        n_compared++;
        if (io_out !== 16'h00C3) begin
            n_mismatched++;
            $display("FAIL io_out_val: got %h want 00C3", io_out);
        end
        n_compared++;
        if (io_out_strobe !== 1'b1) begin
            n_mismatched++;
            $display("FAIL strobe_high: got %b want 1", io_out_strobe);
        end
        cyc();
        drive(16'hFF00, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (io_out_strobe !== 1'b0) begin
            n_mismatched++;
            $display("FAIL strobe_low: got %b want 0", io_out_strobe);
        end
        n_compared++;
        if (dmemrdata !== 16'h00C3) begin
            n_mismatched++;
            $display("FAIL io_out_read: got %h want 00C3", dmemrdata);
        end
        // Back-to-back writes keep the strobe high.
        drive(16'hFF00, 16'h0001, 1'b1, 1'b0);
        cyc();
        drive(16'hFF00, 16'h0002, 1'b1, 1'b0);
        n_compared++;
        if (io_out_strobe !== 1'b1 || io_out !== 16'h0001) begin
            n_mismatched++;
            $display("FAIL b2b_first: got %b/%h want 1/0001", io_out_strobe, io_out);
        end
        cyc();
        idle();
        n_compared++;
        if (io_out_strobe !== 1'b1 || io_out !== 16'h0002) begin
            n_mismatched++;
            $display("FAIL b2b_second: got %b/%h want 1/0002", io_out_strobe, io_out);
        end
        cyc();
        n_compared++;
        if (io_out_strobe !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_end: got %b want 0", io_out_strobe);
        end
        drive(16'hFF00, 16'h00C3, 1'b1, 1'b0);
        cyc();
        idle();
    endtask

    task automatic test_io_in();
        io_in = 16'h7E7E;
        drive(16'hFF02, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL io_in_edge0: got %h want 0000", dmemrdata);
        end
        cyc();
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL io_in_edge1: got %h want 0000", dmemrdata);
        end
        cyc();
        #1;
        n_compared++;
        if (dmemrdata !== 16'h7E7E) begin
            n_mismatched++;
            $display("FAIL io_in_edge2: got %h want 7E7E", dmemrdata);
        end
        // Writes to IO_IN are ignored.
        drive(16'hFF02, 16'h1111, 1'b1, 1'b0);
        cyc();
        drive(16'hFF02, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h7E7E) begin
            n_mismatched++;
            $display("FAIL io_in_ro: got %h want 7E7E", dmemrdata);
        end
        idle();
    endtask

    task automatic test_unmapped();
        drive(16'hFF08, 16'hFFFF, 1'b1, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL unmapped_read: got %h want 0000", dmemrdata);
        end
        cyc();
        drive(16'hFFFE, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0000 || align_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL unmapped_top: got %h/%b want 0000/0", dmemrdata, align_err);
        end
        idle();
    endtask

    task automatic test_cycle();
        drive(16'hFF04, 16'hFFFE, 1'b1, 1'b0);
        cyc();
        drive(16'hFF04, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'hFFFE) begin
            n_mismatched++;
            $display("FAIL cycle_load: got %h want FFFE", dmemrdata);
        end
        cyc();
        #1;
        n_compared++;
        if (dmemrdata !== 16'hFFFF) begin
            n_mismatched++;
            $display("FAIL cycle_inc: got %h want FFFF", dmemrdata);
        end
        cyc();
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL cycle_wrap: got %h want 0000", dmemrdata);
        end
        cyc();
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0001) begin
            n_mismatched++;
            $display("FAIL cycle_resume: got %h want 0001", dmemrdata);
        end
        // Reset mid-count.
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
        drive(16'hFF04, 16'h0000, 1'b0, 1'b1);
        #1;
        n_compared++;
        if (dmemrdata !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL cycle_reset: got %h want 0000", dmemrdata);
        end
        n_compared++;
        if (io_out !== 16'h0000) begin
            n_mismatched++;
            $display("FAIL reset_io_out2: got %h want 0000", io_out);
        end
        dmemaddr = 16'h0010;
        #1;
        n_compared++;
        if (dmemrdata !== 16'h1234) begin
            n_mismatched++;
            $display("FAIL ram_kept: got %h want 1234", dmemrdata);
        end
        idle();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_ram();
        test_rw_same();
        test_align();
        test_io_out();
        test_io_in();
        test_unmapped();
        test_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
